cen_nco_bank: RTL and testbench

CEN_NCO_BANK -- requirements
Module: cen_nco_bank

---
 rtl/cen_nco_bank.sv | 117 +++++++++++
 tb/tb_cen_nco_bank.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cen_nco_bank.sv
// cen_nco_bank
//   Bank of NUM_CH numerically controlled oscillators, one per channel. Each
//   produces single-cycle clock-enable pulses at an average rate of
//   f_refclk * inc / 2^ACC_W. Increments can be retuned glitch-free through a
//   single-entry config slot, and all channels can be realigned with phase_sync.
//
// Ports
//   refclk      in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   cen         out  [NUM_CH] per-channel clock-enable pulses (registered)
//   cfg_valid   in   increment update request
//   cfg_ready   out  update slot free
//   cfg_ch      in   [3] target channel index
//   cfg_inc     in   [ACC_W] new increment
//   cfg_err     out  one-cycle pulse after an out-of-range cfg_ch was accepted
//   phase_sync  in   zero every accumulator and apply any pending update
//   locked      out  high once LOCK_CYCLES cycles have passed without retune/sync
module cen_nco_bank #(
    parameter int                        NUM_CH      = 5,
    parameter int                        ACC_W       = 32,
    parameter logic [NUM_CH*ACC_W-1:0]   INIT_INC    = '0,
    parameter int                        LOCK_CYCLES = 1024
) (
    input  logic              refclk,
    input  logic              rst_n,
    output logic [NUM_CH-1:0] cen,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic              cfg_err,
    input  logic              phase_sync,
    output logic              locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic [ACC_W-1:0] acc [NUM_CH];
    logic [ACC_W-1:0] inc [NUM_CH];
    logic [ACC_W:0]   sum [NUM_CH];

    logic             pend_valid;
    logic [2:0]       pend_ch;
    logic [ACC_W-1:0] pend_inc;

    logic [NUM_CH-1:0] apply_ch;
    logic              apply;
    logic              accept;
    logic              ch_bad;
    logic              pend_valid_next;
    logic [CNT_W-1:0]  lock_cnt;

    // The pending increment lands on the edge where the target channel wraps,
    // so the new value only governs adds after a complete period: no runt or
    // doubled pulse. A stopped channel (inc == 0) never wraps, so it takes the
    // update immediately; a sync edge restarts every phase and so is also safe.
    always_comb begin
        apply_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
            if (pend_valid && (pend_ch == 3'(i)) &&
                (phase_sync || sum[i][ACC_W] || (inc[i] == '0)))
                apply_ch[i] = 1'b1;
        end
        apply  = |apply_ch;
        accept = cfg_valid & cfg_ready;
        ch_bad = ({1'b0, cfg_ch} >= 4'(NUM_CH));

        // Accept is only possible with an empty slot, so fill and apply never
        // coincide.
        pend_valid_next = pend_valid;
        if (apply)
            pend_valid_next = 1'b0;
        if (accept && !ch_bad)
            pend_valid_next = 1'b1;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                inc[i] <= INIT_INC[i*ACC_W +: ACC_W];
            end
            cen        <= '0;
            cfg_ready  <= 1'b0;
            cfg_err    <= 1'b0;
            pend_valid <= 1'b0;
            pend_ch    <= '0;
            pend_inc   <= '0;
            lock_cnt   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= phase_sync ? '0 : sum[i][ACC_W-1:0];
                cen[i] <= ~phase_sync & sum[i][ACC_W];
                if (apply_ch[i])
                    inc[i] <= pend_inc;
            end

            cfg_err    <= accept & ch_bad;
            pend_valid <= pend_valid_next;
            // Also raises ready on the first edge after reset release.
            cfg_ready  <= ~pend_valid_next;
            if (accept && !ch_bad) begin
                pend_ch  <= cfg_ch;
                pend_inc <= cfg_inc;
            end

            if (apply || phase_sync)
                lock_cnt <= '0;
            else if (lock_cnt != CNT_W'(LOCK_CYCLES))
                lock_cnt <= lock_cnt + CNT_W'(1);
        end
    end

    assign locked = (lock_cnt == CNT_W'(LOCK_CYCLES));

endmodule

// File: tb/tb_cen_nco_bank.sv
// tb_cen_nco_bank
//   Directed bench for cen_nco_bank with ACC_W=8, NUM_CH=5, LOCK_CYCLES=16.
//   Reset increments: ch0=64, ch1=64, ch2=32, ch3=96, ch4=0.
module tb_cen_nco_bank;

    localparam int NUM_CH      = 5;
    localparam int ACC_W       = 8;
    localparam int LOCK_CYCLES = 16;
    localparam logic [NUM_CH*ACC_W-1:0] INIT_INC = {8'd0, 8'd96, 8'd32, 8'd64, 8'd64};

    // cen after edges 1..16 following reset release (bit i = channel i)
    localparam logic [4:0] EXP_INIT [16] = '{
        5'b00000, 5'b00000, 5'b01000, 5'b00011,
        5'b00000, 5'b01000, 5'b00000, 5'b01111,
        5'b00000, 5'b00000, 5'b01000, 5'b00011,
        5'b00000, 5'b01000, 5'b00000, 5'b01111
    };

    // cen after edges S+1..S+8 following the phase_sync edge S
    // (ch0=64, ch1=128, ch2=32, ch3 96->128 at its first wrap, ch4=64)
    localparam logic [4:0] EXP_SYNC [8] = '{
        5'b00000, 5'b00010, 5'b01000, 5'b10011,
        5'b01000, 5'b00010, 5'b01000, 5'b10111
    };

    logic              refclk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] cen;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic              cfg_err;
    logic              phase_sync;
    logic              locked;

    int n_tests = 0;
    int n_fail  = 0;

    cen_nco_bank #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .INIT_INC    (INIT_INC),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .cen        (cen),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .cfg_err    (cfg_err),
        .phase_sync (phase_sync),
        .locked     (locked)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        @(negedge refclk);
    endtask

    task automatic run_init_check(input string tag);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check({tag, "_cen"}, 32'(cen), 32'(EXP_INIT[k-1]));
            if (k == 1)
                check({tag, "_ready_first"}, 32'(cfg_ready), 32'd1);
            if (k == 15)
                check({tag, "_locked_lo"}, 32'(locked), 32'd0);
            if (k == 16)
                check({tag, "_locked_hi"}, 32'(locked), 32'd1);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_inc    = '0;
        phase_sync = 1'b0;

        // reset state, with clock edges passing while reset is held
        #12;
        check("rst_cen",    32'(cen),       32'd0);
        check("rst_ready",  32'(cfg_ready), 32'd0);
        check("rst_err",    32'(cfg_err),   32'd0);
        check("rst_locked", 32'(locked),    32'd0);

        @(negedge refclk);
        rst_n = 1'b1;
        run_init_check("init");                  // edges 1..16

        // retune ch1 64 -> 128 while its accumulator is at 0
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_inc = 8'd128;
        tick();                                   // edge 17, accepted
        cfg_valid = 1'b0;
        check("upd_ready_lo17", 32'(cfg_ready), 32'd0);
        check("upd_locked17",   32'(locked),    32'd1);
        tick();                                   // 18
        check("upd_ready_lo18", 32'(cfg_ready), 32'd0);
        check("upd_cen1_18",    32'(cen[1]),    32'd0);
        tick();                                   // 19
        check("upd_ready_lo19", 32'(cfg_ready), 32'd0);
        check("upd_cen1_19",    32'(cen[1]),    32'd0);
        tick();                                   // 20, ch1 wraps and applies
        check("upd_cen1_20",    32'(cen[1]),    32'd1);
        check("upd_ready_hi20", 32'(cfg_ready), 32'd1);
        check("upd_locked20",   32'(locked),    32'd0);
        tick();                                   // 21
        check("upd_cen1_21",    32'(cen[1]),    32'd0);
        tick();                                   // 22
        check("upd_cen1_22",    32'(cen[1]),    32'd1);
        tick();                                   // 23
        check("upd_cen1_23",    32'(cen[1]),    32'd0);
        tick();                                   // 24
        check("upd_cen24",      32'(cen),       32'b01111);
        for (int k = 25; k <= 35; k++)
            tick();
        check("upd_locked35",   32'(locked),    32'd0);
        tick();                                   // 36
        check("upd_locked36",   32'(locked),    32'd1);

        // out-of-range channel
        cfg_valid = 1'b1; cfg_ch = 3'd7; cfg_inc = 8'd5;
        tick();
        cfg_valid = 1'b0;
        check("bad_err_hi",   32'(cfg_err),   32'd1);
        check("bad_ready",    32'(cfg_ready), 32'd1);
        check("bad_locked",   32'(locked),    32'd1);
        tick();
        check("bad_err_lo",   32'(cfg_err),   32'd0);
        check("bad_ready2",   32'(cfg_ready), 32'd1);

        // stopped channel ch4 takes its update on the next cycle
        cfg_valid = 1'b1; cfg_ch = 3'd4; cfg_inc = 8'd64;
        tick();
        cfg_valid = 1'b0;
        check("zero_ready_lo", 32'(cfg_ready), 32'd0);
        tick();
        check("zero_ready_hi", 32'(cfg_ready), 32'd1);
        check("zero_locked",   32'(locked),    32'd0);
        check("zero_cen4",     32'(cen[4]),    32'd0);

        // phase_sync with a coincident ch3 update (96 -> 128)
        phase_sync = 1'b1;
        cfg_valid  = 1'b1; cfg_ch = 3'd3; cfg_inc = 8'd128;
        tick();                                   // edge S
        phase_sync = 1'b0;
        cfg_valid  = 1'b0;
        check("sync_cen0",     32'(cen),       32'd0);
        check("sync_ready_lo", 32'(cfg_ready), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("sync_cen", 32'(cen), 32'(EXP_SYNC[k-1]));
            if (k == 2)
                check("sync_ready_s2", 32'(cfg_ready), 32'd0);
            if (k == 3)
                check("sync_ready_s3", 32'(cfg_ready), 32'd1);
        end
        check("sync_locked", 32'(locked), 32'd0);

        // short reset with an update pending: pending is dropped, INIT_INC back
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_inc = 8'd128;
        tick();
        cfg_valid = 1'b0;
        check("rst2_pend_ready", 32'(cfg_ready), 32'd0);
        @(posedge refclk);
        #1 rst_n = 1'b0;
        #1;
        check("rst2_cen",    32'(cen),       32'd0);
        check("rst2_ready",  32'(cfg_ready), 32'd0);
        check("rst2_err",    32'(cfg_err),   32'd0);
        check("rst2_locked", 32'(locked),    32'd0);
        @(negedge refclk);
        rst_n = 1'b1;
        run_init_check("rst2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
